bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 111 +++++++++++
 tb/tb_bus_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter for the shared system bus.
// M0 is the CPU master and M1 is the DMA controller. The grants and the
// master mux select are decoded only from the state register.
// Optional forced handover after MAX_HOLD cycles: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_grant,
  output logic m1_grant,
  output logic m_sel
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   last_grant_nxt;
  logic   hold_expired;

  // Reject out-of-range hold limits at elaboration time.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be in 2..255");
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;

  // Tenure counter: restarts on every state change and stops at the limit,
  // so a handover still happens once the other master starts requesting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= 8'd0;
    end else if (state_nxt != state) begin
      hold_cnt <= 8'd0;
    end else if (state != IDLE && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign hold_expired = (state != IDLE) && (hold_cnt == HOLD_LAST);
`else
  assign hold_expired = 1'b0;
`endif

  // State and last-granted-master registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next-state logic: the holder keeps the bus while requesting; a waiting
  // master takes over directly on release, with no idle bubble in between.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_nxt = last_grant ? GRANT0 : GRANT1;
        end else if (m0_req) begin
          state_nxt = GRANT0;
        end else if (m1_req) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        if (m1_req && (!m0_req || hold_expired)) begin
          state_nxt = GRANT1;
        end else if (!m0_req) begin
          state_nxt = IDLE;
        end
      end
      GRANT1: begin
        if (m0_req && (!m1_req || hold_expired)) begin
          state_nxt = GRANT0;
        end else if (!m1_req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == GRANT0 && state != GRANT0) begin
      last_grant_nxt = 1'b0;
    end else if (state_nxt == GRANT1 && state != GRANT1) begin
      last_grant_nxt = 1'b1;
    end
  end

  // The grants and the select come from the state flops alone, so an
  // asynchronous reset drops them at once.
  assign m0_grant = (state == GRANT0);
  assign m1_grant = (state == GRANT1);
  assign m_sel    = (state == GRANT1);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random
// request traffic, compared against a tenure-based ownership model.
module tb_bus_arbiter;

  localparam int unsigned MAX_HOLD = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic m0_req;
  logic m1_req;
  logic m0_grant;
  logic m1_grant;
  logic m_sel;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: owner -1 = nobody, 0 = M0, 1 = M1; held = cycles of current tenure.
  int owner;
  int last_m;
  int held;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m1_req   (m1_req),
    .m0_grant (m0_grant),
    .m1_grant (m1_grant),
    .m_sel    (m_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    owner  = -1;
    last_m = 1;
    held   = 0;
  endtask

  task automatic model_edge(input bit r0, input bit r1);
    int nxt;
    bit mine;
    bit theirs;
    nxt = owner;
    if (owner < 0) begin
      if (r0 && r1) nxt = 1 - last_m;
      else if (r0) nxt = 0;
      else if (r1) nxt = 1;
    end else begin
      mine   = (owner == 0) ? r0 : r1;
      theirs = (owner == 0) ? r1 : r0;
      if (theirs && (!mine || (TIMEOUT && held >= int'(MAX_HOLD)))) nxt = 1 - owner;
      else if (!mine) nxt = -1;
    end
    if (nxt != owner) begin
      held = (nxt < 0) ? 0 : 1;
      if (nxt >= 0) last_m = nxt;
    end else if (owner >= 0) begin
      held++;
    end
    owner = nxt;
  endtask

  task automatic check_outputs(input string where);
    check({where, " m0_grant"}, 32'(m0_grant), 32'(owner == 0));
    check({where, " m1_grant"}, 32'(m1_grant), 32'(owner == 1));
    check({where, " m_sel"},    32'(m_sel),    32'(owner == 1));
    check({where, " excl"},     32'(m0_grant & m1_grant), 32'd0);
  endtask

  task automatic step(input bit r0, input bit r1, input string where);
    @(negedge clk);
    m0_req = r0;
    m1_req = r1;
    @(posedge clk);
    #1;
    model_edge(r0, r1);
    check_outputs(where);
  endtask

  initial begin
    int run;
    bit dropped;
    bit r0;
    bit r1;

    reset  = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("in_reset");
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "idle");

    // Lone M1 request held for 6 cycles, then released.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "m1_only");
    check("m1_held grant", 32'(m1_grant), 32'd1);
    step(1'b0, 1'b0, "m1_release");
    check("m1_released grant", 32'(m1_grant), 32'd0);

    // Fresh reset so the first tie goes to M0.
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b1, "tie_first");
    check("tie_first m0_wins", 32'(m0_grant), 32'd1);
    step(1'b1, 1'b1, "tie_hold");
    step(1'b0, 1'b1, "handover");
    check("handover m1_grant", 32'(m1_grant), 32'd1);
    check("handover m0_grant", 32'(m0_grant), 32'd0);
    step(1'b0, 1'b0, "drop_all");
    step(1'b1, 1'b1, "tie_second");
    check("tie_second m0_wins", 32'(m0_grant), 32'd1);

    // Reset in the middle of an M1 tenure with M0 waiting.
    step(1'b0, 1'b0, "pre_rst_idle");
    step(1'b0, 1'b1, "pre_rst_g1");
    step(1'b1, 1'b1, "pre_rst_g1_wait");
    check("pre_rst m1_grant", 32'(m1_grant), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_edge");
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b1, "post_rst_tie");
    check("post_rst m0_wins", 32'(m0_grant), 32'd1);

    // Hold limit: M0 holds its request while M1 requests from grant cycle 1.
    step(1'b0, 1'b0, "hold_idle");
    step(1'b1, 1'b0, "hold_start");
    run = m0_grant ? 1 : 0;
    dropped = !m0_grant;
    for (int i = 0; i < 23; i++) begin
      step(1'b1, 1'b1, "hold");
      if (!dropped && m0_grant) run++;
      else dropped = 1'b1;
    end
    check("hold_run_length", 32'(run), TIMEOUT ? 32'(MAX_HOLD) : 32'd24);

    // Random traffic with sticky requests.
    step(1'b0, 1'b0, "rand_idle");
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) r0 = ~r0;
      if ($urandom_range(3) == 0) r1 = ~r1;
      step(r0, r1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
